// File: rtl/text_writer_pkg.sv
// Shared constants, payload types and helpers for the tile-screen text writer.
package text_writer_pkg;

  localparam int unsigned H_TILES = 160;
  localparam int unsigned V_TILES = 64;
  localparam int unsigned COL_W   = 8;
  localparam int unsigned ROW_W   = 6;
  localparam int unsigned DATA_W  = 7;

  localparam logic [DATA_W-1:0] CH_BS    = 7'h08;
  localparam logic [DATA_W-1:0] CH_LF    = 7'h0A;
  localparam logic [DATA_W-1:0] CH_FF    = 7'h0C;
  localparam logic [DATA_W-1:0] CH_CR    = 7'h0D;
  localparam logic [DATA_W-1:0] CH_SPACE = 7'h20;
  localparam logic [DATA_W-1:0] CH_TILDE = 7'h7E;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // One buffer write: target tile and character code.
  typedef struct packed {
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  // Per-cycle command to a tile counter; clr has highest priority, then inc.
  typedef struct packed {
    logic clr;
    logic inc;
    logic dec_col;
    logic col_rst;
    logic row_inc;
  } cnt_op_t;

  function automatic logic is_printable(input logic [DATA_W-1:0] c);
    return (c >= CH_SPACE) && (c <= CH_TILDE);
  endfunction

endpackage

// File: rtl/text_writer_tile_counter.sv
// Column/row position counter that wraps at the screen edges rather than at powers of two.
module text_writer_tile_counter
  import text_writer_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  cnt_op_t          op_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o
);

  logic col_last;
  logic row_last;

  assign col_last = (col_o == COL_W'(H_TILES - 1));
  assign row_last = (row_o == ROW_W'(V_TILES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || op_i.clr) begin
      col_o <= '0;
      row_o <= '0;
    end else if (op_i.inc) begin
      if (col_last) begin
        col_o <= '0;
        row_o <= row_last ? '0 : row_o + ROW_W'(1);
      end else begin
        col_o <= col_o + COL_W'(1);
      end
    end else begin
      if (op_i.dec_col && (col_o != '0)) begin
        col_o <= col_o - COL_W'(1);
      end else if (op_i.col_rst) begin
        col_o <= '0;
      end
      if (op_i.row_inc) begin
        row_o <= row_last ? '0 : row_o + ROW_W'(1);
      end
    end
  end

endmodule

// File: rtl/text_writer.sv
// Host character stream to tile-buffer write sequencer: cursor tracking, control codes and
// full-screen clear sweep.
module text_writer
  import text_writer_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              char_valid_i,
  input  logic [DATA_W-1:0] char_i,
  output logic              char_ready_o,
  input  logic              clear_i,
  output logic              busy_o,
  output logic              wr_en_o,
  output logic [COL_W-1:0]  col_w_o,
  output logic [ROW_W-1:0]  row_w_o,
  output logic [DATA_W-1:0] din_o,
  output logic [COL_W-1:0]  cursor_col_o,
  output logic [ROW_W-1:0]  cursor_row_o
);

  logic [0:0]       state_q, state_d;
  logic             ready_q;
  logic             busy_q;
  logic             wr_en_q, wr_en_d;
  wr_req_t          wr_q, wr_d;
  cnt_op_t          cur_op, swp_op;
  logic [COL_W-1:0] swp_col;
  logic [ROW_W-1:0] swp_row;
  logic             accept;
  logic             sweep_last;

  // clear_i blocks the handshake in the same cycle so it always wins over a char.
  assign char_ready_o = ready_q && !clear_i;
  assign accept       = char_valid_i && char_ready_o;
  assign sweep_last   = (swp_col == COL_W'(H_TILES - 1)) && (swp_row == ROW_W'(V_TILES - 1));

  text_writer_tile_counter u_cursor (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .op_i  (cur_op),
    .col_o (cursor_col_o),
    .row_o (cursor_row_o)
  );

  text_writer_tile_counter u_sweep (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .op_i  (swp_op),
    .col_o (swp_col),
    .row_o (swp_row)
  );

  always_comb begin
    state_d = state_q;
    wr_en_d = 1'b0;
    wr_d    = wr_q;
    cur_op  = '0;
    swp_op  = '0;
    case (state_q)
      ST_IDLE: begin
        if (clear_i || (accept && (char_i == CH_FF))) begin
          state_d    = ST_CLEAR;
          swp_op.clr = 1'b1;
        end else if (accept) begin
          if (is_printable(char_i)) begin
            wr_en_d    = 1'b1;
            wr_d       = '{col: cursor_col_o, row: cursor_row_o, data: char_i};
            cur_op.inc = 1'b1;
          end else if (char_i == CH_LF) begin
            cur_op.col_rst = 1'b1;
            cur_op.row_inc = 1'b1;
          end else if (char_i == CH_CR) begin
            cur_op.col_rst = 1'b1;
          end else if ((char_i == CH_BS) && (cursor_col_o != '0)) begin
            wr_en_d        = 1'b1;
            wr_d           = '{col: COL_W'(cursor_col_o - COL_W'(1)), row: cursor_row_o,
                               data: CH_SPACE};
            cur_op.dec_col = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        wr_en_d    = 1'b1;
        wr_d       = '{col: swp_col, row: swp_row, data: '0};
        swp_op.inc = 1'b1;
        // Cursor homes together with the final sweep write.
        if (sweep_last) begin
          state_d    = ST_IDLE;
          cur_op.clr = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      wr_en_q <= 1'b0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_q == ST_IDLE) && (state_d == ST_IDLE);
      busy_q  <= (state_q == ST_CLEAR);
      wr_en_q <= wr_en_d;
      wr_q    <= wr_d;
    end
  end

  assign busy_o  = busy_q;
  assign wr_en_o = wr_en_q;
  assign col_w_o = wr_q.col;
  assign row_w_o = wr_q.row;
  assign din_o   = wr_q.data;

endmodule

// File: tb/tb_text_writer.sv
// Directed self-checking bench for text_writer: char table, wrap corners and clear sweeps.
module tb_text_writer;

  localparam int NUM_TILES = 160 * 64;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       char_valid_i = 1'b0;
  logic [6:0] char_i = '0;
  logic       clear_i = 1'b0;
  logic       char_ready_o, busy_o, wr_en_o;
  logic [7:0] col_w_o, cursor_col_o;
  logic [5:0] row_w_o, cursor_row_o;
  logic [6:0] din_o;

  int errors = 0;
  int checks = 0;

  text_writer dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .char_valid_i (char_valid_i),
    .char_i       (char_i),
    .char_ready_o (char_ready_o),
    .clear_i      (clear_i),
    .busy_o       (busy_o),
    .wr_en_o      (wr_en_o),
    .col_w_o      (col_w_o),
    .row_w_o      (row_w_o),
    .din_o        (din_o),
    .cursor_col_o (cursor_col_o),
    .cursor_row_o (cursor_row_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [6:0] ch;
    logic       wr;
    logic [7:0] col;
    logic [5:0] row;
    logic [6:0] din;
    logic [7:0] ccol;
    logic [5:0] crow;
  } vec_t;

  vec_t vecs[25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic send(input logic [6:0] c);
    char_valid_i = 1'b1;
    char_i       = c;
    step();
    char_valid_i = 1'b0;
  endtask

  task automatic chk_write(input string name, input logic [7:0] c, input logic [5:0] r,
                           input logic [6:0] d, input logic [7:0] cc, input logic [5:0] cr);
    chk({name, "_wr"}, wr_en_o, 1'b1);
    chk({name, "_col"}, col_w_o, c);
    chk({name, "_row"}, row_w_o, r);
    chk({name, "_din"}, din_o, d);
    chk({name, "_ccol"}, cursor_col_o, cc);
    chk({name, "_crow"}, cursor_row_o, cr);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    step();
  endtask

  // Call at the negedge right after the edge that starts a sweep.
  task automatic sweep(input string name, input int pulse_at, input int abort_at);
    int nwr = 0, nbusy = 0, cyc = 0, bad_addr = 0, bad_data = 0, gap = 0, bad_cur = 0;
    logic [7:0] ec = '0, scol = cursor_col_o;
    logic [5:0] er = '0, srow = cursor_row_o;
    bit done = 1'b0;
    chk({name, "_entry_wr"}, wr_en_o, 1'b0);
    chk({name, "_entry_busy"}, busy_o, 1'b0);
    while (!done && cyc < 12000) begin
      clear_i = (nwr == pulse_at) && (pulse_at >= 0);
      step();
      cyc++;
      if (wr_en_o) begin
        nwr++;
        if (col_w_o != ec || row_w_o != er) bad_addr++;
        if (din_o != 7'h00) bad_data++;
        if (nwr < NUM_TILES && (cursor_col_o != scol || cursor_row_o != srow)) bad_cur++;
        if (ec == 8'd159) begin ec = '0; er = er + 6'd1; end
        else ec = ec + 8'd1;
      end
      if (busy_o) nbusy++;
      if (wr_en_o != busy_o) gap++;
      if (nwr == abort_at) begin
        clear_i = 1'b0;
        rst_i   = 1'b1;
        step();
        chk({name, "_abort_wr"}, wr_en_o, 1'b0);
        chk({name, "_abort_busy"}, busy_o, 1'b0);
        chk({name, "_abort_cur"}, {cursor_col_o, cursor_row_o}, 14'h0);
        chk({name, "_abort_ready_in_rst"}, char_ready_o, 1'b0);
        rst_i = 1'b0;
        step();
        chk({name, "_abort_ready"}, char_ready_o, 1'b1);
        return;
      end
      if (!busy_o && nwr > 0) done = 1'b1;
    end
    clear_i = 1'b0;
    chk({name, "_terminated"}, done, 1'b1);
    chk({name, "_writes"}, nwr, NUM_TILES);
    chk({name, "_busy_cycles"}, nbusy, NUM_TILES);
    chk({name, "_addr_errs"}, bad_addr, 0);
    chk({name, "_data_errs"}, bad_data, 0);
    chk({name, "_wr_busy_align"}, gap, 0);
    chk({name, "_cursor_held"}, bad_cur, 0);
    chk({name, "_cursor_home"}, {cursor_col_o, cursor_row_o}, 14'h0);
    chk({name, "_ready_back"}, char_ready_o, 1'b1);
  endtask

  initial begin
    // Table: 'A','B', LF x3, 7 chars to (7,3), CR, LF, BS@0, 5 chars, BS, misc codes.
    vecs[0] = '{7'h41, 1, 0, 0, 7'h41, 1, 0};
    vecs[1] = '{7'h42, 1, 1, 0, 7'h42, 2, 0};
    vecs[2] = '{7'h0A, 0, 0, 0, 0, 0, 1};
    vecs[3] = '{7'h0A, 0, 0, 0, 0, 0, 2};
    vecs[4] = '{7'h0A, 0, 0, 0, 0, 0, 3};
    for (int i = 0; i < 7; i++)
      vecs[5 + i] = '{7'(8'h61 + i), 1, 8'(i), 3, 7'(8'h61 + i), 8'(i + 1), 3};
    vecs[12] = '{7'h0D, 0, 0, 0, 0, 0, 3};
    vecs[13] = '{7'h0A, 0, 0, 0, 0, 0, 4};
    vecs[14] = '{7'h08, 0, 0, 0, 0, 0, 4};
    for (int i = 0; i < 5; i++)
      vecs[15 + i] = '{7'(8'h30 + i), 1, 8'(i), 4, 7'(8'h30 + i), 8'(i + 1), 4};
    vecs[20] = '{7'h08, 1, 4, 4, 7'h20, 4, 4};
    vecs[21] = '{7'h07, 0, 0, 0, 0, 4, 4};
    vecs[22] = '{7'h7F, 0, 0, 0, 0, 4, 4};
    vecs[23] = '{7'h7E, 1, 4, 4, 7'h7E, 5, 4};
    vecs[24] = '{7'h1F, 0, 0, 0, 0, 5, 4};

    @(negedge clk_i);
    step();
    chk("rst_wr", wr_en_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_ready", char_ready_o, 1'b0);
    chk("rst_wbus", {col_w_o, row_w_o, din_o}, 21'h0);
    chk("rst_cursor", {cursor_col_o, cursor_row_o}, 14'h0);
    rst_i = 1'b0;
    step();
    chk("ready_after_rst", char_ready_o, 1'b1);

    for (int i = 0; i < 25; i++) begin
      char_valid_i = 1'b1;
      char_i       = vecs[i].ch;
      chk($sformatf("v%0d_ready", i), char_ready_o, 1'b1);
      step();
      chk($sformatf("v%0d_wr", i), wr_en_o, vecs[i].wr);
      if (vecs[i].wr) begin
        chk($sformatf("v%0d_wbus", i), {col_w_o, row_w_o, din_o},
            {vecs[i].col, vecs[i].row, vecs[i].din});
      end
      chk($sformatf("v%0d_cursor", i), {cursor_col_o, cursor_row_o},
          {vecs[i].ccol, vecs[i].crow});
    end
    char_valid_i = 1'b0;
    step();
    chk("idle_no_wr", wr_en_o, 1'b0);

    // Column and screen wrap corners.
    do_reset();
    for (int i = 0; i < 5; i++) send(7'h0A);
    for (int i = 0; i < 159; i++) send(7'h7A);
    send(7'h41);
    chk_write("wrap_col", 8'd159, 6'd5, 7'h41, 8'd0, 6'd6);
    for (int i = 0; i < 57; i++) send(7'h0A);
    for (int i = 0; i < 159; i++) send(7'h7A);
    send(7'h41);
    chk_write("wrap_scr", 8'd159, 6'd63, 7'h41, 8'd0, 6'd0);

    // clear_i beats a simultaneous char.
    send(7'h41);
    chk_write("pre_clr", 8'd0, 6'd0, 7'h41, 8'd1, 6'd0);
    clear_i      = 1'b1;
    char_valid_i = 1'b1;
    char_i       = 7'h51;
    #1;
    chk("clr_blocks_ready", char_ready_o, 1'b0);
    step();
    clear_i      = 1'b0;
    char_valid_i = 1'b0;
    sweep("clr", -1, -1);

    // Form feed sweep with a stray clear_i mid-sweep.
    send(7'h42);
    send(7'h43);
    chk("pre_ff_cursor", {cursor_col_o, cursor_row_o}, {8'd2, 6'd0});
    send(7'h0C);
    sweep("ff", 3000, -1);
    send(7'h44);
    chk_write("post_ff", 8'd0, 6'd0, 7'h44, 8'd1, 6'd0);

    // Reset during a sweep.
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    sweep("abort", -1, 500);
    send(7'h45);
    chk_write("post_abort", 8'd0, 6'd0, 7'h45, 8'd1, 6'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
